// File: rtl/det_pkg.sv
// Shared types for the determinant-of-Hessian feature path.
// Used by det_nms_3x3 and the downstream feature-point collector.
package det_pkg;

    localparam int DET_W      = 32;
    localparam int DET_FRAC_W = 12;
    localparam int FEAT_XY_W  = 16;

    typedef logic signed [DET_W-1:0] det_t;

    typedef struct packed {
        logic [FEAT_XY_W-1:0] x;
        logic [FEAT_XY_W-1:0] y;
        det_t                 det;
    } feat_pt_t;

endpackage

// File: rtl/det_line_buf.sv
// One image row of determinant words: asynchronous read, synchronous write.
// A read of the address being written returns the word stored before the edge.
module det_line_buf
    import det_pkg::*;
#(
    parameter int DEPTH      = 640,
    parameter int DATA_WIDTH = DET_W,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    assign rdata = r_mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/det_nms_3x3.sv
// 3x3 spatial non-maximum suppression on a raster determinant stream.
// Optional threshold gate enabled by defining DET_NMS_THRESH_EN.
module det_nms_3x3
    import det_pkg::*;
#(
    parameter int                           DATA_WIDTH = DET_W,
    parameter int                           IMG_WIDTH  = 640,
    parameter int                           IMG_HEIGHT = 480,
    parameter logic signed [DATA_WIDTH-1:0] DET_THRESH = 32'sd4096
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [DATA_WIDTH-1:0]  det_d,
    input  logic                          det_d_valid,
    output logic                          pt_valid,
    output logic [$clog2(IMG_WIDTH)-1:0]  pt_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] pt_y,
    output logic signed [DATA_WIDTH-1:0]  pt_det,
    output logic                          frame_done
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    logic                          w_smp;
    logic signed [DATA_WIDTH-1:0]  w_a_rd;
    logic signed [DATA_WIDTH-1:0]  w_b_rd;
    logic                          w_is_max;
    logic                          w_thr_ok;
    logic                          w_report;

    logic [XW-1:0]                 r_cx;
    logic [YW-1:0]                 r_cy;
    logic signed [DATA_WIDTH-1:0]  r_win_p0 [3][3];
    logic                          r_vld_p0;
    logic                          r_last_p0;
    logic [XW-1:0]                 r_x_p0;
    logic [YW-1:0]                 r_y_p0;

    // A reset coinciding with a valid pixel drops that pixel everywhere.
    assign w_smp = det_d_valid & ~rst;

    det_line_buf #(.DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_buf_a (
        .clk   (clk),
        .we    (w_smp),
        .addr  (r_cx),
        .wdata (det_d),
        .rdata (w_a_rd)
    );

    det_line_buf #(.DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_buf_b (
        .clk   (clk),
        .we    (w_smp),
        .addr  (r_cx),
        .wdata (w_a_rd),
        .rdata (w_b_rd)
    );

    // ---- stage p0: raster counters and 3x3 window (row 0 = oldest row) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cx      <= '0;
            r_cy      <= '0;
            r_vld_p0  <= 1'b0;
            r_last_p0 <= 1'b0;
            r_x_p0    <= '0;
            r_y_p0    <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win_p0[r][c] <= '0;
                end
            end
        end else begin
            r_vld_p0  <= 1'b0;
            r_last_p0 <= 1'b0;
            if (det_d_valid) begin
                for (int r = 0; r < 3; r++) begin
                    r_win_p0[r][0] <= r_win_p0[r][1];
                    r_win_p0[r][1] <= r_win_p0[r][2];
                end
                r_win_p0[0][2] <= w_b_rd;
                r_win_p0[1][2] <= w_a_rd;
                r_win_p0[2][2] <= det_d;
                r_vld_p0  <= (r_cx >= XW'(2)) && (r_cy >= YW'(2));
                r_last_p0 <= (r_cx == X_LAST) && (r_cy == Y_LAST);
                r_x_p0    <= r_cx - XW'(1);
                r_y_p0    <= r_cy - YW'(1);
                if (r_cx == X_LAST) begin
                    r_cx <= '0;
                    r_cy <= (r_cy == Y_LAST) ? '0 : r_cy + YW'(1);
                end else begin
                    r_cx <= r_cx + XW'(1);
                end
            end
        end
    end

    always_comb begin
        w_is_max = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!(r == 1 && c == 1) && (r_win_p0[1][1] <= r_win_p0[r][c])) begin
                    w_is_max = 1'b0;
                end
            end
        end
    end

`ifdef DET_NMS_THRESH_EN
    assign w_thr_ok = r_win_p0[1][1] > DET_THRESH;
`else
    logic w_unused_thr;
    assign w_unused_thr = ^DET_THRESH;
    assign w_thr_ok     = 1'b1;
`endif

    assign w_report = r_vld_p0 & w_is_max & w_thr_ok;

    // ---- stage p1: registered report, held until the next one ----
    always_ff @(posedge clk) begin
        if (rst) begin
            pt_valid   <= 1'b0;
            pt_x       <= '0;
            pt_y       <= '0;
            pt_det     <= '0;
            frame_done <= 1'b0;
        end else begin
            pt_valid   <= w_report;
            frame_done <= r_last_p0;
            if (w_report) begin
                pt_x   <= r_x_p0;
                pt_y   <= r_y_p0;
                pt_det <= r_win_p0[1][1];
            end
        end
    end

endmodule

// File: tb/tb_det_nms_3x3.sv
// Directed bench for det_nms_3x3 on an 8x6 image with threshold 500.
// Reports and frame_done pulses are logged with the cycle they appear in.
module tb_det_nms_3x3;

    localparam int W = 8;
    localparam int H = 6;

    logic               clk;
    logic               rst;
    logic signed [31:0] det_d;
    logic               det_d_valid;
    logic               pt_valid;
    logic [2:0]         pt_x;
    logic [2:0]         pt_y;
    logic signed [31:0] pt_det;
    logic               frame_done;

    det_nms_3x3 #(
        .DATA_WIDTH (32),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .DET_THRESH (32'sd500)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .det_d       (det_d),
        .det_d_valid (det_d_valid),
        .pt_valid    (pt_valid),
        .pt_x        (pt_x),
        .pt_y        (pt_y),
        .pt_det      (pt_det),
        .frame_done  (frame_done)
    );

    typedef struct {
        int x;
        int y;
        int det;
        int gc;
    } rep_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   gc      = 0;
    int   img     [H][W];
    int   samp_gc [H][W];
    rep_t reps[$];
    int   fds[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Log outputs at the falling edge, then drive the next inputs.
    task automatic tick(input logic r, input logic v, input int d);
        @(negedge clk);
        if (pt_valid === 1'b1)
            reps.push_back('{x: int'(pt_x), y: int'(pt_y), det: int'(pt_det), gc: gc});
        if (frame_done === 1'b1)
            fds.push_back(gc);
        rst         = r;
        det_d_valid = v;
        det_d       = d;
        gc++;
    endtask

    task automatic fill(input int bg);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = bg;
    endtask

    task automatic send_px(input int x, input int y, input int gap);
        samp_gc[y][x] = gc;
        tick(1'b0, 1'b1, img[y][x]);
        repeat (gap) tick(1'b0, 1'b0, 0);
    endtask

    task automatic run_frame(input int gap);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                send_px(x, y, gap);
        repeat (4) tick(1'b0, 1'b0, 0);
    endtask

    task automatic new_case();
        reps.delete();
        fds.delete();
    endtask

    task automatic check_one(input string tag, input int ex, input int ey, input int ed,
                             input int egc);
        check({tag, "_count"}, reps.size(), 1);
        if (reps.size() > 0) begin
            check({tag, "_x"},   reps[0].x,   ex);
            check({tag, "_y"},   reps[0].y,   ey);
            check({tag, "_det"}, reps[0].det, ed);
            check({tag, "_lat"}, reps[0].gc,  egc);
        end
    endtask

    initial begin
        rst         = 1'b1;
        det_d_valid = 1'b0;
        det_d       = '0;

        tick(1'b1, 1'b0, 0);
        tick(1'b1, 1'b0, 0);
        tick(1'b0, 1'b0, 0);
        check("rst_pt_valid",   pt_valid,   0);
        check("rst_pt_x",       pt_x,       0);
        check("rst_pt_y",       pt_y,       0);
        check("rst_pt_det",     pt_det,     0);
        check("rst_frame_done", frame_done, 0);

        // All-zero frame
        new_case();
        fill(0);
        run_frame(0);
        check("zero_reports", reps.size(), 0);
        check("zero_fd_count", fds.size(), 1);
        if (fds.size() > 0) check("zero_fd_lat", fds[0], samp_gc[5][7] + 2);

        // Single peak at (3,2)
        new_case();
        fill(0);
        img[2][3] = 1000;
        run_frame(0);
        check_one("peak", 3, 2, 1000, samp_gc[3][4] + 2);
        check("peak_fd_count", fds.size(), 1);

        // Peak below threshold
        new_case();
        fill(0);
        img[2][3] = 400;
        run_frame(0);
`ifdef DET_NMS_THRESH_EN
        check("low_reports", reps.size(), 0);
`else
        check_one("low", 3, 2, 400, samp_gc[3][4] + 2);
`endif

        // Tie between horizontal neighbours
        new_case();
        fill(0);
        img[2][3] = 1000;
        img[2][4] = 1000;
        run_frame(0);
        check("tie_reports", reps.size(), 0);

        // Peaks on the border only
        new_case();
        fill(0);
        img[0][0] = 5000;
        img[5][7] = 5000;
        run_frame(0);
        check("border_reports", reps.size(), 0);

        // Negative values need signed comparison
        new_case();
        fill(-100);
        img[3][5] = -50;
        run_frame(0);
`ifdef DET_NMS_THRESH_EN
        check("neg_reports", reps.size(), 0);
`else
        check_one("neg", 5, 3, -50, samp_gc[4][6] + 2);
`endif

        // Sparse valid, reset mid row 3, then a full sparse frame
        new_case();
        fill(0);
        img[3][2] = 3000;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < W; x++)
                send_px(x, y, 2);
        for (int x = 0; x < 3; x++)
            send_px(x, 3, 2);
        tick(1'b1, 1'b1, 7777);
        tick(1'b0, 1'b0, 0);
        tick(1'b0, 1'b0, 0);
        fill(0);
        img[2][2] = 2000;
        run_frame(2);
        check_one("gap", 2, 2, 2000, samp_gc[3][3] + 2);
        check("gap_fd_count", fds.size(), 1);
        if (fds.size() > 0) check("gap_fd_lat", fds[0], samp_gc[5][7] + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/det_nms_3x3.md
# det_nms_3x3

Spatial non-maximum suppression stage that sits directly downstream of the Hessian determinant stage. It consumes the raster-ordered determinant stream (`det_d` / `det_d_valid`) and buffers two image rows to form a 3x3 window. It reports each interior pixel whose determinant is strictly greater than all 8 neighbours, and, when enabled, above a fixed threshold. Reports carry coordinates and value to the downstream feature-point collector.

## Interface
- `DATA_WIDTH`, 32: determinant width; signed two's complement, 12 fractional bits.
- `IMG_WIDTH`, 640: pixels per row; minimum 3.
- `IMG_HEIGHT`, 480: rows per frame; minimum 3.
- `DET_THRESH`, 32'sd4096: signed threshold (1.0 in Q.12).
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `det_d`  in  DATA_WIDTH  determinant of current pixel; sampled only when `det_d_valid`=1.
- `det_d_valid`  in  1  pixel strobe; may have arbitrary gaps; no backpressure.
- `pt_valid`  out  1  one-cycle strobe: a feature point is reported.
- `pt_x`  out  $clog2(IMG_WIDTH)  column of the reported point.
- `pt_y`  out  $clog2(IMG_HEIGHT)  row of the reported point.
- `pt_det`  out  DATA_WIDTH  determinant of the reported point.
- `frame_done`  out  1  one-cycle strobe after the last pixel of a frame.

## Operation
- Column counter `cx` and row counter `cy` advance once per sampled pixel, in raster order.
  - `cx` wraps from IMG_WIDTH-1 to 0 and increments `cy`.
  - After pixel (IMG_WIDTH-1, IMG_HEIGHT-1) both counters return to 0. The next sample is pixel (0,0) of a new frame.
- Two line buffers are chained and indexed by `cx`:
  - Buffer A holds row cy-1; buffer B holds row cy-2.
  - On each sample, the old words are read, B[cx] is written with A[cx], and A[cx] is written with `det_d`.
- A 3x3 window register array shifts one column left per sample. It loads {B[cx], A[cx], det_d} into its right column.
- When the sampled pixel is (x+1, y+1), the window centre is (x, y).
- A candidate is evaluated only when the sampled pixel satisfies cx≥2 and cy≥2. This means the centre satisfies 1≤x≤IMG_WIDTH-2 and 1≤y≤IMG_HEIGHT-2.
  - Border pixels are never reported.
  - The window never mixes data across a row wrap.
- Candidate condition: centre > each of the 8 neighbours, using a signed comparison. Any tie with a neighbour suppresses the candidate.
- Because the bottom row is border, no flush is needed at end of frame. The final candidate (IMG_WIDTH-2, IMG_HEIGHT-2) is decided by the last pixel of the frame.
- Reset clears the counters, the window and all outputs; line-buffer contents are not cleared.
  - A reset mid-frame discards the partial frame.
  - The next sample after reset is pixel (0,0).
  - Stale buffer data is never used, because of the cy≥2 gating.

## Timing
- Pipeline stages:
  - Edge t samples pixel (x+1, y+1) and updates the window.
  - Edge t+1 registers the compare result, the centre coordinates and the centre value.
- `pt_valid`, `pt_x`, `pt_y` and `pt_det` become valid after edge t+1: 2-cycle latency from the sampling edge. They are held until the next report; only `pt_valid` pulses.
- `frame_done` pulses after edge t+1, where t is the edge sampling (IMG_WIDTH-1, IMG_HEIGHT-1). It is coincident with any report for (IMG_WIDTH-2, IMG_HEIGHT-2).
- Gaps in `det_d_valid` stall the window; no report is generated in a gap cycle.
- Reset values: `pt_valid`=0, `pt_x`=0, `pt_y`=0, `pt_det`=0, `frame_done`=0.
- Reset asserted in the same cycle as `det_d_valid`: reset wins and the sample is dropped.
- Throughput: one pixel per clock, sustained.

## Configuration
- `DET_NMS_THRESH_EN` defined: a candidate also requires centre > DET_THRESH (signed, strict).
- `DET_NMS_THRESH_EN` undefined: the threshold compare is not built, `DET_THRESH` is ignored, and every strict local maximum is reported.
- Ports and latency are identical in both builds.

## Structure
- Shared package `det_pkg`:
  - `DET_W`=32 and `DET_FRAC_W`=12.
  - typedef `det_t` (signed [DET_W-1:0]).
  - typedef `feat_pt_t` {x, y, det}, for use by the downstream collector.
- Sub-module `det_line_buf`:
  - Depth IMG_WIDTH, DATA_WIDTH words.
  - Asynchronous read, synchronous write on `we`; read-during-write returns the old word.
  - Instantiated twice.
- Top level contains the counters, the window registers, the 8-way compare and the output register stage.

## Test plan
All scenarios use IMG_WIDTH=8, IMG_HEIGHT=6, DET_THRESH=500, with `det_d_valid` continuously high unless stated.
- All-zero frame -> no `pt_valid`; `frame_done` pulses exactly once, 2 cycles after pixel (7,5) is sampled.
- Background 0, (3,2)=1000 -> exactly one report: `pt_x`=3, `pt_y`=2, `pt_det`=1000, 2 cycles after pixel (4,3) is sampled.
- Background 0, (3,2)=400 -> no report with `DET_NMS_THRESH_EN`; one report (3,2,400) without it.
- Tie: (3,2)=(4,2)=1000, background 0 -> no report. Border peaks (0,0)=5000 and (7,5)=5000 -> no report.
- Signed compare, macro off: background -100, (5,3)=-50 -> one report (5,3,-50).
- `det_d_valid` high every third cycle, with `rst` asserted for one cycle mid-row 3, then a full frame with (2,2)=2000 -> exactly one report, (2,2,2000); no report from the aborted frame.
